dma_mem_cpu_cpu_ocimem_arbiter: RTL and testbench

- Sequences the on-chip debug memory (OCI RAM) accesses requested by the JTAG debug slave's system-clock decode strobes (take_action_ocimem_a/b, take_no_action_ocimem_a, jdo).
- Shares the single-port RAM with the CPU debug-mode data port using round-robin arbitration.
- Returns JTAG read data in MonDReg, with monitor_ready/monitor_error status.
- Sits between the debug slave wrapper and the OCI RAM macro in the clk domain.

---
 rtl/dma_mem_cpu_cpu_ocimem_pkg.sv | 17 +
 rtl/dma_mem_cpu_cpu_ocimem_arbiter_if.sv | 48 ++++
 rtl/dma_mem_cpu_cpu_ocimem_rr_arb.sv | 36 +++
 rtl/dma_mem_cpu_cpu_ocimem_arbiter.sv | 135 +++++++++++++
 tb/tb_dma_mem_cpu_cpu_ocimem_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_mem_cpu_cpu_ocimem_pkg.sv
// Shared types and jdo field positions for the OCI RAM arbiter.
package dma_mem_cpu_cpu_ocimem_pkg;

  typedef enum logic [1:0] {IDLE, RD_J, RD_C} state_e;

  typedef enum logic [1:0] {OP_ADDR, OP_ADDR_RD, OP_WR, OP_RD_INC} jtag_op_e;

  // Who owned the RAM on the most recent issue cycle.
  typedef enum logic {GNT_JTAG = 1'b0, GNT_CPU = 1'b1} gnt_e;

  // The address and data fields overlap; each strobe uses only its own field.
  localparam int ADDR_LSB    = 17;
  localparam int DATA_LSB    = 3;
  localparam int RD_BIT      = 35;
  localparam int CLR_ERR_BIT = 36;

endpackage

// File: rtl/dma_mem_cpu_cpu_ocimem_arbiter_if.sv
// Bus bundle: JTAG strobes, CPU debug port, OCI RAM port and monitor status.
interface dma_mem_cpu_cpu_ocimem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int JDO_W  = 38
) ();
  logic [JDO_W-1:0]  jdo;
  logic              take_action_ocimem_a;
  logic              take_action_ocimem_b;
  logic              take_no_action_ocimem_a;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [3:0]        cpu_be;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              ram_cs;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [3:0]        ram_be;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] MonDReg;
  logic              monitor_ready;
  logic              monitor_error;

  // Arbiter side.
  modport slave (
    input  jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output ram_cs, ram_we, ram_addr, ram_wdata, ram_be,
    input  ram_rdata,
    output MonDReg, monitor_ready, monitor_error
  );

  // Environment side: debug slave, CPU and RAM macro.
  modport master (
    output jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  ram_cs, ram_we, ram_addr, ram_wdata, ram_be,
    output ram_rdata,
    input  MonDReg, monitor_ready, monitor_error
  );
endinterface

// File: rtl/dma_mem_cpu_cpu_ocimem_rr_arb.sv
// Two-requester round-robin: on a tie the requester that did not win last time goes.
module dma_mem_cpu_cpu_ocimem_rr_arb
  import dma_mem_cpu_cpu_ocimem_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_req_j,
  input  logic i_req_c,
  output logic o_gnt_j,
  output logic o_gnt_c
);
  gnt_e r_last;

  // Grant decision, only while the RAM is free.
  always_comb begin
    o_gnt_j = 1'b0;
    o_gnt_c = 1'b0;
    if (i_en) begin
      if (i_req_j && i_req_c) begin
        o_gnt_j = (r_last == GNT_CPU);
        o_gnt_c = (r_last == GNT_JTAG);
      end else begin
        o_gnt_j = i_req_j;
        o_gnt_c = i_req_c;
      end
    end
  end

  // Remember the winner; starts at CPU so JTAG takes the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_last <= GNT_CPU;
    else if (o_gnt_j) r_last <= GNT_JTAG;
    else if (o_gnt_c) r_last <= GNT_CPU;
  end
endmodule

// File: rtl/dma_mem_cpu_cpu_ocimem_arbiter.sv
// OCI RAM sequencer: decodes JTAG strobes into a one-deep pending command and
// shares the single-port RAM with the CPU debug port.
module dma_mem_cpu_cpu_ocimem_arbiter
  import dma_mem_cpu_cpu_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int JDO_W  = 38
) (
  input logic clk,
  input logic reset,
  dma_mem_cpu_cpu_ocimem_arbiter_if.slave bus
);
  state_e            r_state, w_state_nxt;
  jtag_op_e          r_op;
  logic              r_jtag_pend;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_mon;
  logic              r_ready, r_error;

  logic w_a, w_b, w_n, w_any, w_multi, w_accept, w_drop;
  logic w_req_j, w_gnt_j, w_gnt_c;
  logic w_j_wr_done, w_j_rd_done, w_addr_done;
  logic w_unused;

  assign w_a      = bus.take_action_ocimem_a;
  assign w_b      = bus.take_action_ocimem_b;
  assign w_n      = bus.take_no_action_ocimem_a;
  assign w_any    = w_a | w_b | w_n;
  assign w_multi  = (w_a & w_b) | (w_a & w_n) | (w_b & w_n);
  assign w_accept = w_any & ~r_jtag_pend;
  assign w_drop   = w_multi | (w_any & r_jtag_pend);
  assign w_unused = ^{bus.jdo[DATA_LSB-1:0], bus.jdo[JDO_W-1:CLR_ERR_BIT+1]};

  // An address-only load needs no RAM slot, so it never competes for one.
  assign w_req_j     = r_jtag_pend & (r_op != OP_ADDR);
  assign w_j_wr_done = w_gnt_j & (r_op == OP_WR);
  assign w_j_rd_done = (r_state == RD_J);
  assign w_addr_done = r_jtag_pend & (r_op == OP_ADDR);

  dma_mem_cpu_cpu_ocimem_rr_arb u_arb (
    .clk     (clk),
    .reset   (reset),
    .i_en    ((r_state == IDLE) & ~reset),
    .i_req_j (w_req_j),
    .i_req_c (bus.cpu_req),
    .o_gnt_j (w_gnt_j),
    .o_gnt_c (w_gnt_c)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state: reads spend one cycle collecting ram_rdata.
  always_comb begin
    w_state_nxt = IDLE;
    if (r_state == IDLE) begin
      if (w_gnt_j && (r_op != OP_WR))   w_state_nxt = RD_J;
      else if (w_gnt_c && !bus.cpu_we) w_state_nxt = RD_C;
    end
  end

  // RAM port, driven in the issue cycle by whichever side was granted.
  always_comb begin
    bus.ram_cs    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    bus.ram_be    = 4'h0;
    if (w_gnt_j) begin
      bus.ram_cs   = 1'b1;
      bus.ram_we   = (r_op == OP_WR);
      bus.ram_addr = r_addr;
      if (r_op == OP_WR) begin
        bus.ram_wdata = r_wdata;
        bus.ram_be    = 4'hF;
      end
    end else if (w_gnt_c) begin
      bus.ram_cs   = 1'b1;
      bus.ram_we   = bus.cpu_we;
      bus.ram_addr = bus.cpu_addr;
      if (bus.cpu_we) begin
        bus.ram_wdata = bus.cpu_wdata;
        bus.ram_be    = bus.cpu_be;
      end
    end
  end

  // JTAG command capture, completion, address pointer and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_jtag_pend <= 1'b0;
      r_op        <= OP_ADDR;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_mon       <= '0;
      r_ready     <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_jtag_pend <= 1'b1;
        r_ready     <= 1'b0;
        if (w_a) begin
          r_op   <= bus.jdo[RD_BIT] ? OP_ADDR_RD : OP_ADDR;
          r_addr <= bus.jdo[ADDR_LSB +: ADDR_W];
        end else if (w_b) begin
          r_op    <= OP_WR;
          r_wdata <= bus.jdo[DATA_LSB +: DATA_W];
        end else begin
          r_op <= OP_RD_INC;
        end
      end else if (w_j_wr_done || w_j_rd_done || w_addr_done) begin
        r_jtag_pend <= 1'b0;
        r_ready     <= 1'b1;
        if (w_j_wr_done || (w_j_rd_done && (r_op == OP_RD_INC)))
          r_addr <= r_addr + 1'b1;
      end
      if (w_j_rd_done) r_mon <= bus.ram_rdata;
      // A drop in the same cycle as a clear request keeps the error visible.
      if (w_drop)                                     r_error <= 1'b1;
      else if (w_accept && w_a && bus.jdo[CLR_ERR_BIT]) r_error <= 1'b0;
    end
  end

  assign bus.cpu_gnt       = w_gnt_c;
  assign bus.cpu_rvalid    = (r_state == RD_C);
  assign bus.cpu_rdata     = (r_state == RD_C) ? bus.ram_rdata : '0;
  assign bus.MonDReg       = r_mon;
  assign bus.monitor_ready = r_ready;
  assign bus.monitor_error = r_error;
endmodule

// File: tb/tb_dma_mem_cpu_cpu_ocimem_arbiter.sv
// Scoreboard bench: expected RAM accesses, CPU read data and JTAG completions
// are queued as stimulus is driven and popped as the DUT produces them.
module tb_dma_mem_cpu_cpu_ocimem_arbiter;
  localparam int AW = 8, DW = 32, JW = 38;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dma_mem_cpu_cpu_ocimem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .JDO_W(JW)) bus ();

  dma_mem_cpu_cpu_ocimem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .JDO_W(JW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem     [0:255];
  logic [31:0] exp_mem [0:255];
  logic [7:0]  exp_addr;
  logic [31:0] exp_mon;
  logic [45:0] ram_q [$];
  logic [31:0] cpu_q [$];
  logic [31:0] jq    [$];
  logic        prev_rdy;
  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // RAM macro: one-cycle read latency, byte-enabled writes.
  always @(posedge clk) begin
    if (bus.ram_cs && bus.ram_we)
      for (int k = 0; k < 4; k++)
        if (bus.ram_be[k]) mem[bus.ram_addr][8*k +: 8] = bus.ram_wdata[8*k +: 8];
    if (bus.ram_cs && !bus.ram_we) bus.ram_rdata <= mem[bus.ram_addr];
  end

  function automatic logic [45:0] ram_e(input logic c, input logic we, input logic [7:0] a,
                                        input logic [31:0] d, input logic [3:0] be);
    return {c, we, a, (we ? d : 32'h0), (we ? be : 4'h0)};
  endfunction

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    logic [45:0] obs;
    if (reset) begin
      prev_rdy <= 1'b0;
    end else begin
      if (bus.ram_cs) begin
        obs = {bus.cpu_gnt, bus.ram_we, bus.ram_addr,
               (bus.ram_we ? bus.ram_wdata : 32'h0), (bus.ram_we ? bus.ram_be : 4'h0)};
        if (ram_q.size() == 0) chk("ram_unexpected", ram_q.size(), 1);
        else                   chk("ram_access", obs, ram_q.pop_front());
      end
      if (bus.cpu_gnt && !bus.cpu_req) chk("gnt_without_req", bus.cpu_req, 1);
      if (bus.cpu_rvalid) begin
        if (cpu_q.size() == 0) chk("rvalid_unexpected", cpu_q.size(), 1);
        else                   chk("cpu_rdata", bus.cpu_rdata, cpu_q.pop_front());
      end
      if (bus.monitor_ready && !prev_rdy) begin
        if (jq.size() == 0) chk("ready_unexpected", jq.size(), 1);
        else                chk("mondreg", bus.MonDReg, jq.pop_front());
      end
      prev_rdy <= bus.monitor_ready;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] mk_a(input logic [7:0] a, input logic rd, input logic clr);
    logic [37:0] j;
    j = '0;
    j[24:17] = a;
    j[35] = rd;
    j[36] = clr;
    return j;
  endfunction

  function automatic logic [37:0] mk_b(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  task automatic jstrobe(input logic a, input logic b, input logic n, input logic [37:0] j);
    bus.take_action_ocimem_a    = a;
    bus.take_action_ocimem_b    = b;
    bus.take_no_action_ocimem_a = n;
    bus.jdo = j;
    tick();
    bus.take_action_ocimem_a    = 1'b0;
    bus.take_action_ocimem_b    = 1'b0;
    bus.take_no_action_ocimem_a = 1'b0;
    bus.jdo = '0;
  endtask

  task automatic j_a(input logic [7:0] a, input logic rd, input logic clr);
    exp_addr = a;
    if (rd) begin
      ram_q.push_back(ram_e(1'b0, 1'b0, a, 32'h0, 4'h0));
      exp_mon = exp_mem[a];
    end
    jq.push_back(exp_mon);
    jstrobe(1'b1, 1'b0, 1'b0, mk_a(a, rd, clr));
  endtask

  task automatic j_write(input logic [31:0] d);
    ram_q.push_back(ram_e(1'b0, 1'b1, exp_addr, d, 4'hF));
    exp_mem[exp_addr] = d;
    exp_addr++;
    jq.push_back(exp_mon);
    jstrobe(1'b0, 1'b1, 1'b0, mk_b(d));
  endtask

  task automatic j_read();
    ram_q.push_back(ram_e(1'b0, 1'b0, exp_addr, 32'h0, 4'h0));
    exp_mon = exp_mem[exp_addr];
    exp_addr++;
    jq.push_back(exp_mon);
    jstrobe(1'b0, 1'b0, 1'b1, '0);
  endtask

  // Holds cpu_req until granted; lat counts cycles from the first sample.
  task automatic cpu_wait_gnt(output int lat);
    lat = 0;
    @(negedge clk);
    while (!bus.cpu_gnt && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    tick();
    bus.cpu_req = 1'b0;
  endtask

  task automatic settle();
    int k;
    k = 0;
    while ((ram_q.size() + cpu_q.size() + jq.size()) != 0 && k < 30) begin
      @(posedge clk);
      k++;
    end
    tick(3);
    chk("drain", ram_q.size() + cpu_q.size() + jq.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    exp_addr = 8'h00;
    exp_mon  = 32'h0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int lat;
    reset = 1'b1;
    bus.jdo = '0;
    bus.take_action_ocimem_a = 1'b0;
    bus.take_action_ocimem_b = 1'b0;
    bus.take_no_action_ocimem_a = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0;
    bus.cpu_wdata = '0; bus.cpu_be = 4'h0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = {16'hC0DE, i[7:0], ~i[7:0]};
      exp_mem[i] = {16'hC0DE, i[7:0], ~i[7:0]};
    end
    mem[8'h10] = 32'hDEADBEEF;
    exp_mem[8'h10] = 32'hDEADBEEF;
    exp_addr = 8'h00;
    exp_mon  = 32'h0;

    // Outputs held at zero in reset, even with a CPU request present.
    tick(2);
    bus.cpu_req = 1'b1;
    @(negedge clk);
    chk("rst_ram_cs", bus.ram_cs, 0);
    chk("rst_cpu_gnt", bus.cpu_gnt, 0);
    chk("rst_rvalid", bus.cpu_rvalid, 0);
    chk("rst_ready", bus.monitor_ready, 0);
    chk("rst_error", bus.monitor_error, 0);
    chk("rst_mondreg", bus.MonDReg, 0);
    bus.cpu_req = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // a-strobe with read: MonDReg/ready three cycles after the strobe.
    j_a(8'h10, 1'b1, 1'b0);
    tick();
    chk("rd_ready_early", bus.monitor_ready, 0);
    tick();
    chk("rd_ready_lat3", bus.monitor_ready, 1);
    chk("rd_mondreg_lat3", bus.MonDReg, 32'hDEADBEEF);
    settle();
    j_read();                    // still 0x10: the a-read does not increment
    settle();

    // Write at 0xFF, pointer wraps to 0x00.
    j_a(8'hFF, 1'b0, 1'b0);
    settle();
    j_write(32'h12345678);
    chk("wr_ready_early", bus.monitor_ready, 0);
    tick();
    chk("wr_ready_lat2", bus.monitor_ready, 1);
    settle();
    j_read();
    settle();
    j_a(8'hFF, 1'b1, 1'b0);
    settle();

    // Tie straight after reset: JTAG first, CPU two cycles later.
    do_reset();
    j_read();
    ram_q.push_back(ram_e(1'b1, 1'b0, 8'h20, 32'h0, 4'h0));
    cpu_q.push_back(exp_mem[8'h20]);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h20;
    cpu_wait_gnt(lat);
    chk("tie1_gnt_lat", lat, 2);
    settle();
    j_read();                    // JTAG wins alone, so the next tie goes to CPU
    settle();
    ram_q.push_back(ram_e(1'b1, 1'b0, 8'h21, 32'h0, 4'h0));
    cpu_q.push_back(exp_mem[8'h21]);
    j_read();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h21;
    cpu_wait_gnt(lat);
    chk("tie2_gnt_lat", lat, 0);
    settle();

    // CPU byte-enabled write, read back over JTAG.
    ram_q.push_back(ram_e(1'b1, 1'b1, 8'h22, 32'hAABBCCDD, 4'b0101));
    for (int k = 0; k < 4; k++)
      if (k == 0 || k == 2) exp_mem[8'h22][8*k +: 8] = 8'(32'hAABBCCDD >> (8*k));
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h22;
    bus.cpu_wdata = 32'hAABBCCDD; bus.cpu_be = 4'b0101;
    cpu_wait_gnt(lat);
    chk("cpu_wr_gnt_lat", lat, 0);
    bus.cpu_we = 1'b0;
    settle();
    j_a(8'h22, 1'b1, 1'b0);
    settle();

    // a and b together: only the address load happens, error set.
    chk("err_clear_before", bus.monitor_error, 0);
    exp_addr = 8'h40;
    jq.push_back(exp_mon);
    jstrobe(1'b1, 1'b1, 1'b0, mk_a(8'h40, 1'b0, 1'b0));
    settle();
    chk("err_multi_strobe", bus.monitor_error, 1);
    j_read();
    settle();
    j_a(8'h41, 1'b0, 1'b1);
    settle();
    chk("err_cleared", bus.monitor_error, 0);

    // Strobe while a command is pending: dropped, pointer untouched.
    j_read();
    jstrobe(1'b1, 1'b0, 1'b0, mk_a(8'h77, 1'b1, 1'b0));
    settle();
    chk("err_pend_drop", bus.monitor_error, 1);
    j_read();
    settle();

    // Reset while in RD_C: read discarded, everything zero.
    ram_q.push_back(ram_e(1'b1, 1'b0, 8'h60, 32'h0, 4'h0));
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h60;
    @(negedge clk);
    tick();
    reset = 1'b1;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    chk("rdc_rst_rvalid", bus.cpu_rvalid, 0);
    chk("rdc_rst_rdata", bus.cpu_rdata, 0);
    chk("rdc_rst_ram_cs", bus.ram_cs, 0);
    chk("rdc_rst_ready", bus.monitor_ready, 0);
    chk("rdc_rst_error", bus.monitor_error, 0);
    chk("rdc_rst_mondreg", bus.MonDReg, 0);
    tick();
    reset = 1'b0;
    exp_addr = 8'h00;
    exp_mon  = 32'h0;
    tick(4);
    settle();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
